seq_arith_shifter: RTL and testbench

- Multi-cycle 32-bit arithmetic shift unit for the KGP_RISC execute stage.
- Complements the existing combinational logic shifter: covers arithmetic right (sign-fill) and left shifts.
- Shifts one bit position per clock under a start/busy/done handshake, so no wide barrel network is needed.
- The control unit stalls the pipeline while busy=1.

---
 rtl/seq_arith_shifter.sv | 110 +++++++++++
 tb/tb_seq_arith_shifter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_shifter.sv
// seq_arith_shifter
//   Multi-cycle arithmetic shift unit for the execute stage. Shifts one bit
//   position per clock: arithmetic right (sign fill) or left (zero fill).
//   The pipeline stalls while busy is high.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request pulse, sampled only when not busy
//   A      in   operand, captured on accepted start
//   shamt  in   shift amount, captured on accepted start (>= WIDTH saturates)
//   dir    in   1 = arithmetic right, 0 = left; captured on accepted start
//   busy   out  operation in progress
//   done   out  one-cycle pulse, res valid from this cycle on
//   res    out  result, held until the next completed operation
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | one bit per edge until the count reaches zero, then latch res
// S_DONE  | done pulse; a start here is accepted like in S_IDLE
module seq_arith_shifter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [31:0]      shamt,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNTW-1:0]  load_cnt;

  // Amounts of WIDTH or more all give the same result, so clamp to WIDTH.
  always_comb begin
    if (shamt >= 32'(WIDTH)) begin
      load_cnt = CNTW'(WIDTH);
    end else begin
      load_cnt = shamt[CNTW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          sh_d    = A;
          dir_d   = dir;
          cnt_d   = load_cnt;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          if (dir_q) begin
            sh_d = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
          end else begin
            sh_d = {sh_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          res_d   = sh_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign res  = res_q;

endmodule

// File: tb/tb_seq_arith_shifter.sv
module tb_seq_arith_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] shamt;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int errors = 0;
  int checks = 0;

  seq_arith_shifter #(.WIDTH(32), .CNTW(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .shamt (shamt),
    .dir   (dir),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issues start in the current cycle (T) and waits for done, bounded.
  // lat = cycles from T to the done cycle; busy_n = busy cycles seen before it.
  task automatic do_op(input logic [31:0] a, input logic [31:0] sh, input logic d,
                       output int lat, output int busy_n, output logic [31:0] r);
    A = a; shamt = sh; dir = d; start = 1'b1;
    busy_n = 0;
    cyc();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      cyc();
      lat++;
    end
    r = res;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 32'hFFFF_FFFF; shamt = 32'd3; dir = 1'b1;
    cyc(); cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res got=%h exp=00000000", res); end
    rst = 1'b0; start = 1'b0;
    cyc();
  endtask

  task automatic test_right_shift();
    int lat, bn; logic [31:0] r;
    do_op(32'h8000_0010, 32'd4, 1'b1, lat, bn, r);
    checks++; if (lat !== 6) begin errors++; $display("FAIL right_lat got=%0d exp=6", lat); end
    checks++; if (bn !== 5) begin errors++; $display("FAIL right_busy_cycles got=%0d exp=5", bn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL right_busy_at_done got=%b exp=0", busy); end
    checks++; if (r !== 32'hF800_0001) begin errors++; $display("FAIL right_res got=%h exp=f8000001", r); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL right_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_left_shift();
    int lat, bn; logic [31:0] r;
    do_op(32'h0000_0001, 32'd31, 1'b0, lat, bn, r);
    checks++; if (lat !== 33) begin errors++; $display("FAIL left31_lat got=%0d exp=33", lat); end
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL left31_res got=%h exp=80000000", r); end
    cyc();
    do_op(32'h1234_5678, 32'd8, 1'b0, lat, bn, r);
    checks++; if (lat !== 10) begin errors++; $display("FAIL left8_lat got=%0d exp=10", lat); end
    checks++; if (r !== 32'h3456_7800) begin errors++; $display("FAIL left8_res got=%h exp=34567800", r); end
    cyc();
  endtask

  task automatic test_zero_shift();
    int lat, bn; logic [31:0] r;
    do_op(32'hDEAD_BEEF, 32'd0, 1'b1, lat, bn, r);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_lat got=%0d exp=2", lat); end
    checks++; if (bn !== 1) begin errors++; $display("FAIL zero_busy_cycles got=%0d exp=1", bn); end
    checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_res got=%h exp=deadbeef", r); end
    cyc();
  endtask

  task automatic test_saturation();
    int lat, bn; logic [31:0] r;
    do_op(32'h8000_0000, 32'd100, 1'b1, lat, bn, r);
    checks++; if (lat !== 34) begin errors++; $display("FAIL sat_r_lat got=%0d exp=34", lat); end
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_r_neg_res got=%h exp=ffffffff", r); end
    cyc();
    do_op(32'h7FFF_FFFF, 32'd100, 1'b1, lat, bn, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL sat_r_pos_res got=%h exp=00000000", r); end
    cyc();
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bn, r);
    checks++; if (lat !== 34) begin errors++; $display("FAIL sat_l_lat got=%0d exp=34", lat); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL sat_l_res got=%h exp=00000000", r); end
    cyc();
    do_op(32'h8000_0000, 32'd32, 1'b1, lat, bn, r);
    checks++; if (lat !== 34) begin errors++; $display("FAIL sat32_lat got=%0d exp=34", lat); end
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat32_res got=%h exp=ffffffff", r); end
    cyc();
  endtask

  task automatic test_start_while_busy();
    int lat;
    A = 32'h0000_00F0; shamt = 32'd4; dir = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0; lat = 1;
    cyc(); lat++;
    A = 32'hFFFF_FFFF; shamt = 32'd0; dir = 1'b0; start = 1'b1;
    cyc(); lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      cyc(); lat++;
    end
    checks++; if (lat !== 6) begin errors++; $display("FAIL ignore_lat got=%0d exp=6", lat); end
    checks++; if (res !== 32'h0000_000F) begin errors++; $display("FAIL ignore_res got=%h exp=0000000f", res); end
    repeat (5) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done got=%b exp=0", done); end
    checks++; if (res !== 32'h0000_000F) begin errors++; $display("FAIL hold_res got=%h exp=0000000f", res); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; logic [31:0] r;
    do_op(32'h1234_5678, 32'd4, 1'b1, lat, bn, r);
    checks++; if (r !== 32'h0123_4567) begin errors++; $display("FAIL b2b_first_res got=%h exp=01234567", r); end
    do_op(32'h8000_0001, 32'd2, 1'b0, lat, bn, r);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_second_lat got=%0d exp=4", lat); end
    checks++; if (r !== 32'h0000_0004) begin errors++; $display("FAIL b2b_second_res got=%h exp=00000004", r); end
    cyc();
  endtask

  task automatic test_reset_mid_op();
    int lat, bn, done_seen; logic [31:0] r;
    A = 32'h0000_FFFF; shamt = 32'd16; dir = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL midrst_res got=%h exp=00000000", res); end
    done_seen = 0;
    repeat (20) begin
      if (done || busy) done_seen++;
      cyc();
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", done_seen); end
    do_op(32'hFFFF_0000, 32'd16, 1'b1, lat, bn, r);
    checks++; if (lat !== 18) begin errors++; $display("FAIL after_rst_lat got=%0d exp=18", lat); end
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL after_rst_res got=%h exp=ffffffff", r); end
    cyc();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; shamt = '0; dir = 1'b0;
    test_reset();
    test_right_shift();
    test_left_shift();
    test_zero_shift();
    test_saturation();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
